alu_wb_ctrl: RTL and testbench
==============================

# alu_wb_ctrl

Sequential write-back controller on the output side of `alu`. It accepts one ALU result per handshake and sequences it onto the single register-file write port. For dual-result operations it writes the destination register first and R15 second. On `ovExcep` it suppresses all register writes, latches the faulting PC and holds an exception request until the control unit acknowledges it.

## Interface
Parameters:
- `DATA_W`, 16, register and PC width
- `ADDR_W`, 4, register-file address width
- `R15_ADDR`, 4'hF, address used for the secondary result

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, asynchronous and active-high
- `inValid`  input  1  ALU result presented this cycle
- `inReady`  output  1  controller can accept a result
- `aluRslt`  input  32  primary ALU result; bits [15:0] are written to Rd, bits [31:16] are ignored
- `aluRsltR15`  input  16  secondary result (multiply high word / divide remainder)
- `ovExcep`  input  1  ALU overflow flag for the presented result
- `destReg`  input  4  Rd address
- `wrR15`  input  1  operation also writes R15
- `pcIn`  input  16  PC of the instruction producing the result
- `regWrite`  output  1  register-file write enable
- `wrAddr`  output  4  register-file write address
- `wrData`  output  16  register-file write data
- `excReq`  output  1  overflow exception pending
- `epc`  output  16  PC of the faulting instruction
- `excAck`  input  1  control unit has taken the exception

## Operation
- States: IDLE, WR_RD, WR_R15, EXC.
- `inReady` is 1 only in IDLE; it is decoded combinationally from state.
- A result is accepted on a rising edge in IDLE when `inValid` is 1.
- On acceptance, `aluRslt[15:0]`, `aluRsltR15`, `destReg`, `wrR15` and `pcIn` are captured into holding registers. Later input changes have no effect.
- Transitions:
  - IDLE, accept, `ovExcep=1` -> EXC. `epc` is loaded with `pcIn`. No register write occurs, even if `wrR15=1`.
  - IDLE, accept, `ovExcep=0` -> WR_RD.
  - WR_RD -> WR_R15 if the captured `wrR15` is 1, else -> IDLE.
  - WR_R15 -> IDLE.
  - EXC -> IDLE when `excAck` is 1. Otherwise EXC holds and `inValid` is ignored.
- Outputs by state:
  - WR_RD: `regWrite=1`, `wrAddr`=captured Rd, `wrData`=captured `aluRslt[15:0]`.
  - WR_R15: `regWrite=1`, `wrAddr=R15_ADDR`, `wrData`=captured `aluRsltR15`.
  - EXC: `excReq=1`.
  - All other states: `regWrite=0`, `excReq=0`.
- Rd = 15 with `wrR15=1`: both writes are issued in order, so R15 ends holding `aluRsltR15`.
- `epc` changes only on exception acceptance or reset. It holds its value after `excAck`.
- `excAck` outside EXC is ignored.

## Timing
- Reset (asynchronous, immediate) forces:
  - state IDLE, so `inReady=1`;
  - `regWrite=0`, `wrAddr=0`, `wrData=0`;
  - `excReq=0`, `epc=0`;
  - holding registers cleared.
- Reset during WR_RD or WR_R15 aborts the sequence; no further write is issued.
- Reset during EXC clears `excReq` without requiring `excAck`.
- Latency, accept edge to first `regWrite`: 1 cycle.
- The R15 write follows the Rd write on the next cycle.
- Throughput: single result, 1 accept per 2 cycles; dual result, 1 per 3 cycles.
- `excReq` rises 1 cycle after the accept edge. It falls on the edge where `excAck=1` is sampled. `inReady` returns on that same edge.
- `wrAddr` and `wrData` are registered. They hold their last values when `regWrite=0`.

## Test plan
- Single write: reset, then accept `aluRslt=32'h0000_0FFF`, `destReg=3`, `wrR15=0`, `ovExcep=0`. Required: next cycle `regWrite=1`, `wrAddr=3`, `wrData=16'h0FFF`; the cycle after, `regWrite=0` and `inReady=1`.
- Dual write: accept `aluRslt=32'h0000_E100`, `aluRsltR15=16'h00E1`, `destReg=2`, `wrR15=1`. Required:
  - cycle 1: write of `16'hE100` to register 2;
  - cycle 2: write of `16'h00E1` to register 15;
  - `inReady=0` for 2 cycles.
- Overflow: accept `aluRslt=32'h0001_E1E0`, `ovExcep=1`, `pcIn=16'h0040`, `wrR15=1`. Required:
  - no `regWrite` pulse;
  - `excReq=1` and `epc=16'h0040` held with `excAck=0` for 5 cycles;
  - `excAck=1` -> `excReq=0` and `inReady=1` on the next edge.
- Blocking: drive `inValid=1` continuously with changing data. Required: accepts occur only in IDLE cycles, and each write shows the data captured at its own accept edge.
- Rd=15 with `wrR15=1`: `aluRslt=16'h1111`, `aluRsltR15=16'h2222`. Required: two writes to address 15, the second carrying `16'h2222`.
- Mid-operation reset: assert `rst` during WR_RD of a dual-result op, and separately during EXC. Required: immediately `regWrite=0`, `excReq=0`, `epc=0`, `inReady=1`; no R15 write after reset release.

Source files
------------

// File: rtl/alu_wb_ctrl.sv
// alu_wb_ctrl: sequences one ALU result per handshake onto the single
// register-file write port. Dual-result operations write Rd first and then
// R15. On overflow, all writes are suppressed, the faulting PC is latched and
// an exception request is held until the control unit acknowledges it.
module alu_wb_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] R15_ADDR = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inValid,
    output logic                inReady,
    input  logic [2*DATA_W-1:0] aluRslt,
    input  logic [DATA_W-1:0]   aluRsltR15,
    input  logic                ovExcep,
    input  logic [ADDR_W-1:0]   destReg,
    input  logic                wrR15,
    input  logic [DATA_W-1:0]   pcIn,
    output logic                regWrite,
    output logic [ADDR_W-1:0]   wrAddr,
    output logic [DATA_W-1:0]   wrData,
    output logic                excReq,
    output logic [DATA_W-1:0]   epc,
    input  logic                excAck
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_RD  = 2'd1,
        WR_R15 = 2'd2,
        EXC    = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic [DATA_W-1:0]   hold_r15_data;
    logic                hold_wr_r15;

    // The upper half of the primary result never reaches the register file.
    logic unused_rslt_hi;
    assign unused_rslt_hi = ^aluRslt[2*DATA_W-1:DATA_W];

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the state-decoded handshake/control outputs.
    // NOTE: every output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        inReady  = 1'b0;
        regWrite = 1'b0;
        excReq   = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    accept  = 1'b1;
                    state_d = ovExcep ? EXC : WR_RD;
                end
            end
            WR_RD: begin
                regWrite = 1'b1;
                state_d  = hold_wr_r15 ? WR_R15 : IDLE;
            end
            WR_R15: begin
                regWrite = 1'b1;
                state_d  = IDLE;
            end
            EXC: begin
                excReq = 1'b1;
                if (excAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the result at accept and stage the write port one cycle ahead
    // of each write state; wrAddr/wrData hold when no write is scheduled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r15_data <= '0;
            hold_wr_r15   <= 1'b0;
            wrAddr        <= '0;
            wrData        <= '0;
            epc           <= '0;
        end else if (accept) begin
            hold_r15_data <= aluRsltR15;
            hold_wr_r15   <= wrR15;
            if (ovExcep) begin
                epc <= pcIn;
            end else begin
                wrAddr <= destReg;
                wrData <= aluRslt[DATA_W-1:0];
            end
        end else if (state_q == WR_RD && hold_wr_r15) begin
            wrAddr <= R15_ADDR;
            wrData <= hold_r15_data;
        end
    end

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Directed testbench for alu_wb_ctrl: hand-computed expected values for
// single, dual, overflow, back-to-back, Rd=15 and mid-operation reset cases.
module tb_alu_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] aluRslt;
    logic [15:0] aluRsltR15;
    logic        ovExcep;
    logic [3:0]  destReg;
    logic        wrR15;
    logic [15:0] pcIn;
    logic        regWrite;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic        excReq;
    logic [15:0] epc;
    logic        excAck;

    int n_checks = 0;
    int n_errors = 0;

    alu_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .inValid    (inValid),
        .inReady    (inReady),
        .aluRslt    (aluRslt),
        .aluRsltR15 (aluRsltR15),
        .ovExcep    (ovExcep),
        .destReg    (destReg),
        .wrR15      (wrR15),
        .pcIn       (pcIn),
        .regWrite   (regWrite),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .excReq     (excReq),
        .epc        (epc),
        .excAck     (excAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] r, input logic [15:0] r15, input logic ov,
                           input logic [3:0] rd, input logic w15, input logic [15:0] pc);
        inValid    = 1'b1;
        aluRslt    = r;
        aluRsltR15 = r15;
        ovExcep    = ov;
        destReg    = rd;
        wrR15      = w15;
        pcIn       = pc;
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; aluRslt = '0; aluRsltR15 = '0; ovExcep = 1'b0;
        destReg = '0; wrR15 = 1'b0; pcIn = '0; excAck = 1'b0;
        #1;
        check("rst_inReady", 32'(inReady), 32'd1);
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_wrAddr", 32'(wrAddr), 32'd0);
        check("rst_wrData", 32'(wrData), 32'd0);
        check("rst_excReq", 32'(excReq), 32'd0);
        check("rst_epc", 32'(epc), 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Single write
        present(32'h0000_0FFF, 16'hAAAA, 1'b0, 4'd3, 1'b0, 16'h0010);
        step();
        inValid = 1'b0;
        check("sgl_regWrite", 32'(regWrite), 32'd1);
        check("sgl_wrAddr", 32'(wrAddr), 32'd3);
        check("sgl_wrData", 32'(wrData), 32'h0FFF);
        check("sgl_inReady_busy", 32'(inReady), 32'd0);
        step();
        check("sgl_regWrite_off", 32'(regWrite), 32'd0);
        check("sgl_inReady_back", 32'(inReady), 32'd1);
        check("sgl_wrAddr_hold", 32'(wrAddr), 32'd3);

        // Dual write; inputs change after accept and must not matter
        present(32'h0000_E100, 16'h00E1, 1'b0, 4'd2, 1'b1, 16'h0012);
        step();
        present(32'h0000_5555, 16'h6666, 1'b0, 4'd7, 1'b0, 16'h0000);
        inValid = 1'b0;
        check("dual_w1_regWrite", 32'(regWrite), 32'd1);
        check("dual_w1_wrAddr", 32'(wrAddr), 32'd2);
        check("dual_w1_wrData", 32'(wrData), 32'hE100);
        check("dual_w1_inReady", 32'(inReady), 32'd0);
        step();
        check("dual_w2_regWrite", 32'(regWrite), 32'd1);
        check("dual_w2_wrAddr", 32'(wrAddr), 32'hF);
        check("dual_w2_wrData", 32'(wrData), 32'h00E1);
        check("dual_w2_inReady", 32'(inReady), 32'd0);
        step();
        check("dual_end_regWrite", 32'(regWrite), 32'd0);
        check("dual_end_inReady", 32'(inReady), 32'd1);

        // Overflow: no write, exception held while excAck=0, inValid ignored
        present(32'h0001_E1E0, 16'h1234, 1'b1, 4'd5, 1'b1, 16'h0040);
        step();
        present(32'h0000_0001, 16'h0002, 1'b0, 4'd1, 1'b0, 16'h0099);
        for (int i = 0; i < 5; i++) begin
            check("ov_excReq", 32'(excReq), 32'd1);
            check("ov_epc", 32'(epc), 32'h0040);
            check("ov_regWrite", 32'(regWrite), 32'd0);
            check("ov_inReady", 32'(inReady), 32'd0);
            step();
        end
        inValid = 1'b0;
        excAck  = 1'b1;
        step();
        excAck = 1'b0;
        check("ack_excReq", 32'(excReq), 32'd0);
        check("ack_inReady", 32'(inReady), 32'd1);
        check("ack_epc_hold", 32'(epc), 32'h0040);
        check("ack_regWrite", 32'(regWrite), 32'd0);
        check("ack_wrAddr_hold", 32'(wrAddr), 32'hF);
        // excAck in IDLE is ignored
        excAck = 1'b1;
        step();
        excAck = 1'b0;
        check("idle_ack_inReady", 32'(inReady), 32'd1);
        check("idle_ack_excReq", 32'(excReq), 32'd0);

        // Blocking: inValid held high, data changes every cycle.
        // Accept on even i (IDLE), WR_RD on odd i -> even-i data only.
        for (int i = 0; i < 8; i++) begin
            present({16'h0000, 16'h1000 + 16'(i)}, 16'h0000, 1'b0, 4'(i), 1'b0, 16'h0000);
            step();
            if (i % 2 == 0) begin
                check("blk_regWrite_on", 32'(regWrite), 32'd1);
                check("blk_wrAddr", 32'(wrAddr), 32'(i));
                check("blk_wrData", 32'(wrData), 32'h1000 + 32'(i));
            end else begin
                check("blk_regWrite_off", 32'(regWrite), 32'd0);
                check("blk_inReady", 32'(inReady), 32'd1);
            end
        end
        inValid = 1'b0;
        step();

        // Rd = 15 with wrR15
        present(32'h0000_1111, 16'h2222, 1'b0, 4'hF, 1'b1, 16'h0020);
        step();
        inValid = 1'b0;
        check("r15_w1_regWrite", 32'(regWrite), 32'd1);
        check("r15_w1_wrAddr", 32'(wrAddr), 32'hF);
        check("r15_w1_wrData", 32'(wrData), 32'h1111);
        step();
        check("r15_w2_regWrite", 32'(regWrite), 32'd1);
        check("r15_w2_wrAddr", 32'(wrAddr), 32'hF);
        check("r15_w2_wrData", 32'(wrData), 32'h2222);
        step();
        check("r15_end_regWrite", 32'(regWrite), 32'd0);

        // Reset during WR_RD of a dual op (epc is still 0x0040 here)
        present(32'h0000_ABCD, 16'hDCBA, 1'b0, 4'd6, 1'b1, 16'h0030);
        step();
        inValid = 1'b0;
        check("mrst_pre_regWrite", 32'(regWrite), 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_regWrite", 32'(regWrite), 32'd0);
        check("mrst_inReady", 32'(inReady), 32'd1);
        check("mrst_wrAddr", 32'(wrAddr), 32'd0);
        check("mrst_wrData", 32'(wrData), 32'd0);
        check("mrst_epc", 32'(epc), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("mrst_no_r15_regWrite", 32'(regWrite), 32'd0);
        check("mrst_no_r15_wrAddr", 32'(wrAddr), 32'd0);
        step();
        check("mrst_idle_regWrite", 32'(regWrite), 32'd0);

        // Reset during EXC
        present(32'h0000_7FFF, 16'h0000, 1'b1, 4'd1, 1'b0, 16'h0080);
        step();
        inValid = 1'b0;
        check("erst_pre_excReq", 32'(excReq), 32'd1);
        check("erst_pre_epc", 32'(epc), 32'h0080);
        rst = 1'b1;
        #1;
        check("erst_excReq", 32'(excReq), 32'd0);
        check("erst_epc", 32'(epc), 32'd0);
        check("erst_inReady", 32'(inReady), 32'd1);
        check("erst_regWrite", 32'(regWrite), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("erst_after_excReq", 32'(excReq), 32'd0);
        check("erst_after_inReady", 32'(inReady), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
